// File: rtl/hit_judge_pkg.sv
// Shared types and constants for the hit judge: bus widths, game_state codes
// and the scan FSM encoding.
package hit_judge_pkg;

   localparam int unsigned COORD_W = 10;
   localparam int unsigned HP_W    = 8;
   localparam int unsigned GS_W    = 4;

   // Game-control FSM state codes, common to the FSM and this block
   localparam logic [GS_W-1:0] GS_INITIAL   = 4'b0000;
   localparam logic [GS_W-1:0] GS_START     = 4'b0001;
   localparam logic [GS_W-1:0] GS_PLAY      = 4'b0010;
   localparam logic [GS_W-1:0] GS_COLLISION = 4'b1010;
   localparam logic [GS_W-1:0] GS_BOMB      = 4'b0110;
   localparam logic [GS_W-1:0] GS_SUCCESS   = 4'b1000;
   localparam logic [GS_W-1:0] GS_GAMEOVER  = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_REPORT = 2'd2
   } judge_state_t;

endpackage

// File: rtl/hit_judge_if.sv
// Bus between the game FSM / bullet engines (master) and the hit judge (slave).
interface hit_judge_if;
   import hit_judge_pkg::*;

   logic               game_reset;
   logic               game_en;
   logic [GS_W-1:0]    game_state;
   logic               frame_start;
   logic [COORD_W-1:0] player_x;
   logic [COORD_W-1:0] player_y;
   logic [COORD_W-1:0] boss_x;
   logic [COORD_W-1:0] boss_y;
   logic               eb_valid;
   logic [COORD_W-1:0] eb_x;
   logic [COORD_W-1:0] eb_y;
   logic               eb_last;
   logic               eb_ready;
   logic               pb_valid;
   logic [COORD_W-1:0] pb_x;
   logic [COORD_W-1:0] pb_y;
   logic               pb_last;
   logic               pb_ready;
   logic               collision;
   logic               die;
   logic [HP_W-1:0]    boss_hp;
   logic               overrun;

   modport master (
      output game_reset, game_en, game_state, frame_start,
      output player_x, player_y, boss_x, boss_y,
      output eb_valid, eb_x, eb_y, eb_last,
      output pb_valid, pb_x, pb_y, pb_last,
      input  eb_ready, pb_ready, collision, die, boss_hp, overrun
   );

   modport slave (
      input  game_reset, game_en, game_state, frame_start,
      input  player_x, player_y, boss_x, boss_y,
      input  eb_valid, eb_x, eb_y, eb_last,
      input  pb_valid, pb_x, pb_y, pb_last,
      output eb_ready, pb_ready, collision, die, boss_hp, overrun
   );

endinterface

// File: rtl/hit_judge_hit_window.sv
// Square hitbox test: inclusive |dx|<=R and |dy|<=R on unsigned coordinates.
module hit_window #(
   parameter int unsigned COORD_W = 10,
   parameter int unsigned R       = 3
) (
   input  logic [COORD_W-1:0] ax,
   input  logic [COORD_W-1:0] ay,
   input  logic [COORD_W-1:0] bx,
   input  logic [COORD_W-1:0] by,
   output logic               hit_c
);

   logic [COORD_W-1:0] dx;
   logic [COORD_W-1:0] dy;

   // max minus min never wraps, so the difference is the true distance
   always_comb begin
      dx    = (ax >= bx) ? (ax - bx) : (bx - ax);
      dy    = (ay >= by) ? (ay - by) : (by - ay);
      hit_c = (32'(dx) <= R) && (32'(dy) <= R);
   end

endmodule

// File: rtl/hit_judge.sv
// Per-frame bullet/hitbox scan: raises collision for the player, tracks boss
// HP and holds die once the boss is defeated.
module hit_judge
   import hit_judge_pkg::*;
#(
   parameter int unsigned PLAYER_R     = 3,
   parameter int unsigned BOSS_R       = 24,
   parameter int unsigned BOSS_HP_INIT = 200
) (
   input logic        clk,
   input logic        hard_reset_n,
   hit_judge_if.slave bus
);

   localparam logic [HP_W-1:0] HP_INIT = HP_W'(BOSS_HP_INIT);
   localparam logic [HP_W-1:0] HIT_MAX = '1;

   judge_state_t    state_q, state_d;
   logic            hit_flag_q, hit_flag_d;
   logic            eb_done_q, eb_done_d;
   logic            pb_done_q, pb_done_d;
   logic [HP_W-1:0] hit_cnt_q, hit_cnt_d;
   logic [HP_W-1:0] boss_hp_q, boss_hp_d;
   logic            die_q, die_d;
   logic            collision_q, collision_d;
   logic            overrun_q, overrun_d;
   logic            eb_ready_q, eb_ready_d;
   logic            pb_ready_q, pb_ready_d;
   logic            start_scan;
   logic            eb_hit_c, pb_hit_c;
   logic            eb_acc_c, pb_acc_c;
   logic            hp_live_c;

   hit_window #(.COORD_W(COORD_W), .R(PLAYER_R)) u_player_win (
      .ax(bus.player_x), .ay(bus.player_y),
      .bx(bus.eb_x),     .by(bus.eb_y),
      .hit_c(eb_hit_c)
   );

   hit_window #(.COORD_W(COORD_W), .R(BOSS_R)) u_boss_win (
      .ax(bus.boss_x), .ay(bus.boss_y),
      .bx(bus.pb_x),   .by(bus.pb_y),
      .hit_c(pb_hit_c)
   );

   assign eb_acc_c  = (state_q == ST_SCAN) && bus.eb_valid && !eb_done_q;
   assign pb_acc_c  = (state_q == ST_SCAN) && bus.pb_valid && !pb_done_q;
   assign hp_live_c = bus.game_state inside {GS_PLAY, GS_COLLISION, GS_BOMB};

   assign bus.eb_ready  = eb_ready_q;
   assign bus.pb_ready  = pb_ready_q;
   assign bus.collision = collision_q;
   assign bus.die       = die_q;
   assign bus.boss_hp   = boss_hp_q;
   assign bus.overrun   = overrun_q;

   // Next-state and output logic; the frame verdict is committed on the edge
   // that closes the scan, so collision appears in the REPORT cycle.
   always_comb begin
      state_d     = state_q;
      hit_flag_d  = hit_flag_q;
      eb_done_d   = eb_done_q;
      pb_done_d   = pb_done_q;
      hit_cnt_d   = hit_cnt_q;
      boss_hp_d   = boss_hp_q;
      die_d       = die_q || (boss_hp_q == '0);
      collision_d = 1'b0;
      overrun_d   = 1'b0;
      start_scan  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.frame_start && bus.game_en) start_scan = 1'b1;
         end
         ST_SCAN: begin
            if (bus.frame_start) begin
               overrun_d  = 1'b1;
               start_scan = 1'b1;
            end else begin
               if (eb_acc_c && eb_hit_c) hit_flag_d = 1'b1;
               if (pb_acc_c && pb_hit_c && (hit_cnt_q != HIT_MAX))
                  hit_cnt_d = hit_cnt_q + HP_W'(1);
               if (eb_acc_c && bus.eb_last) eb_done_d = 1'b1;
               if (pb_acc_c && bus.pb_last) pb_done_d = 1'b1;
               if (eb_done_d && pb_done_d) begin
                  state_d     = ST_REPORT;
                  collision_d = hit_flag_d && (bus.game_state == GS_PLAY) &&
                                bus.game_en && !die_q;
                  if (hp_live_c)
                     boss_hp_d = (boss_hp_q > hit_cnt_d) ? (boss_hp_q - hit_cnt_d) : '0;
               end
            end
         end
         ST_REPORT: begin
            if (bus.frame_start) begin
               overrun_d  = 1'b1;
               start_scan = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (start_scan) begin
         state_d    = ST_SCAN;
         hit_flag_d = 1'b0;
         eb_done_d  = 1'b0;
         pb_done_d  = 1'b0;
         hit_cnt_d  = '0;
      end

      // game_reset wins over every other update this cycle
      if (bus.game_reset) begin
         state_d     = ST_IDLE;
         hit_flag_d  = 1'b0;
         eb_done_d   = 1'b0;
         pb_done_d   = 1'b0;
         hit_cnt_d   = '0;
         boss_hp_d   = HP_INIT;
         die_d       = 1'b0;
         collision_d = 1'b0;
         overrun_d   = 1'b0;
      end

      eb_ready_d = (state_d == ST_SCAN) && !eb_done_d;
      pb_ready_d = (state_d == ST_SCAN) && !pb_done_d;
   end

   always_ff @(posedge clk or negedge hard_reset_n) begin
      if (!hard_reset_n) begin
         state_q     <= ST_IDLE;
         hit_flag_q  <= 1'b0;
         eb_done_q   <= 1'b0;
         pb_done_q   <= 1'b0;
         hit_cnt_q   <= '0;
         boss_hp_q   <= HP_INIT;
         die_q       <= 1'b0;
         collision_q <= 1'b0;
         overrun_q   <= 1'b0;
         eb_ready_q  <= 1'b0;
         pb_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hit_flag_q  <= hit_flag_d;
         eb_done_q   <= eb_done_d;
         pb_done_q   <= pb_done_d;
         hit_cnt_q   <= hit_cnt_d;
         boss_hp_q   <= boss_hp_d;
         die_q       <= die_d;
         collision_q <= collision_d;
         overrun_q   <= overrun_d;
         eb_ready_q  <= eb_ready_d;
         pb_ready_q  <= pb_ready_d;
      end
   end

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed frames plus randomized frames checked against
// a frame-level model of hits, HP and die.
module tb_hit_judge;
   import hit_judge_pkg::*;

   localparam int P_R  = 3;
   localparam int B_R  = 24;
   localparam int HP0  = 200;
   localparam int OFFS = 1023;

   typedef struct {
      int x;
      int y;
   } beat_t;

   logic clk = 1'b0;
   logic hard_reset_n = 1'b0;
   always #5 clk = ~clk;

   hit_judge_if jif();

   hit_judge #(.PLAYER_R(P_R), .BOSS_R(B_R), .BOSS_HP_INIT(HP0)) dut (
      .clk(clk),
      .hard_reset_n(hard_reset_n),
      .bus(jif.slave)
   );

   int    total = 0;
   int    bad   = 0;
   int    m_hp  = HP0;
   bit    m_die = 1'b0;
   int    px, py, bx, by;
   beat_t eb_q[$];
   beat_t pb_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic bit in_win(beat_t b, int cx, int cy, int r);
      int dx, dy;
      dx = (b.x > cx) ? b.x - cx : cx - b.x;
      dy = (b.y > cy) ? b.y - cy : cy - b.y;
      return (dx <= r) && (dy <= r);
   endfunction

   function automatic beat_t near(int cx, int cy, int span);
      beat_t b;
      b.x = cx + int'($urandom_range(0, 2 * span)) - span;
      b.y = cy + int'($urandom_range(0, 2 * span)) - span;
      return b;
   endfunction

   function automatic beat_t mk(int x, int y);
      beat_t b;
      b.x = x;
      b.y = y;
      return b;
   endfunction

   task automatic place(input int ppx, input int ppy, input int bbx, input int bby);
      px = ppx; py = ppy; bx = bbx; by = bby;
      jif.player_x = 10'(ppx);
      jif.player_y = 10'(ppy);
      jif.boss_x   = 10'(bbx);
      jif.boss_y   = 10'(bby);
   endtask

   task automatic start_frame();
      @(negedge clk);
      jif.frame_start = 1'b1;
      jif.game_en     = 1'b1;
      @(negedge clk);
      jif.frame_start = 1'b0;
   endtask

   // Feeds both queues with random gaps; returns at the negedge after the
   // edge that accepted the final beat of the slower stream.
   task automatic drive_scan(input bit en_scan, output bit ok, output int spur);
      int ei = 0;
      int pi = 0;
      int cyc = 0;
      spur = 0;
      jif.game_en = en_scan;
      while ((ei < eb_q.size() || pi < pb_q.size()) && cyc < 600) begin
         if (jif.collision) spur++;
         if (ei < eb_q.size() && $urandom_range(0, 3) != 0) begin
            jif.eb_valid = 1'b1;
            jif.eb_x     = 10'(eb_q[ei].x);
            jif.eb_y     = 10'(eb_q[ei].y);
            jif.eb_last  = (ei == eb_q.size() - 1);
            if (jif.eb_ready) ei++;
         end else begin
            jif.eb_valid = 1'b0;
            jif.eb_x     = 10'($urandom);
            jif.eb_y     = 10'($urandom);
            jif.eb_last  = 1'($urandom);
         end
         if (pi < pb_q.size() && $urandom_range(0, 3) != 0) begin
            jif.pb_valid = 1'b1;
            jif.pb_x     = 10'(pb_q[pi].x);
            jif.pb_y     = 10'(pb_q[pi].y);
            jif.pb_last  = (pi == pb_q.size() - 1);
            if (jif.pb_ready) pi++;
         end else begin
            jif.pb_valid = 1'b0;
            jif.pb_x     = 10'($urandom);
            jif.pb_y     = 10'($urandom);
            jif.pb_last  = 1'($urandom);
         end
         cyc++;
         @(negedge clk);
      end
      jif.eb_valid = 1'b0;
      jif.pb_valid = 1'b0;
      ok = (cyc < 600);
   endtask

   // Checks one frame's verdict against the model; pass skip_start=1 when
   // the scan was already (re)started by the caller.
   task automatic run_frame(input string tag, input logic [3:0] gs, input bit en_scan,
                            input bit skip_start);
      int hits = 0;
      bit any = 1'b0;
      bit ok;
      int spur;
      bit exp_col;
      foreach (eb_q[i]) if (in_win(eb_q[i], px, py, P_R)) any = 1'b1;
      foreach (pb_q[i]) if (in_win(pb_q[i], bx, by, B_R)) hits++;
      if (hits > 255) hits = 255;
      jif.game_state = gs;
      if (!skip_start) start_frame();
      drive_scan(en_scan, ok, spur);
      check_eq({tag, "_scan_done"}, 32'(ok), 1);
      check_eq({tag, "_early_col"}, spur, 0);
      exp_col = any && (gs == GS_PLAY) && en_scan && !m_die;
      if (gs inside {GS_PLAY, GS_COLLISION, GS_BOMB})
         m_hp = (m_hp > hits) ? m_hp - hits : 0;
      check_eq({tag, "_collision"}, 32'(jif.collision), 32'(exp_col));
      check_eq({tag, "_boss_hp"}, 32'(jif.boss_hp), m_hp);
      check_eq({tag, "_die_hold"}, 32'(jif.die), 32'(m_die));
      @(negedge clk);
      check_eq({tag, "_col_end"}, 32'(jif.collision), 0);
      m_die = m_die || (m_hp == 0);
      check_eq({tag, "_die"}, 32'(jif.die), 32'(m_die));
      check_eq({tag, "_idle_rdy"}, 32'(jif.eb_ready), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      jif.game_reset  = 1'b0;
      jif.game_en     = 1'b0;
      jif.game_state  = GS_PLAY;
      jif.frame_start = 1'b0;
      jif.eb_valid = 1'b0; jif.eb_x = '0; jif.eb_y = '0; jif.eb_last = 1'b0;
      jif.pb_valid = 1'b0; jif.pb_x = '0; jif.pb_y = '0; jif.pb_last = 1'b0;
      place(100, 100, 300, 50);

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_hp", 32'(jif.boss_hp), HP0);
      check_eq("rst_eb_ready", 32'(jif.eb_ready), 0);
      check_eq("rst_die", 32'(jif.die), 0);
      check_eq("rst_col", 32'(jif.collision), 0);
      hard_reset_n = 1'b1;

      // frame_start ignored while game disabled
      @(negedge clk);
      jif.frame_start = 1'b1;
      jif.game_en     = 1'b0;
      @(negedge clk);
      jif.frame_start = 1'b0;
      check_eq("en0_ignored", 32'(jif.eb_ready), 0);

      // Player hit in PLAY, then invulnerable states
      eb_q = '{mk(110, 100), mk(102, 98)};
      pb_q = '{mk(OFFS, OFFS)};
      run_frame("t1", GS_PLAY, 1'b1, 1'b0);
      run_frame("t2c", GS_COLLISION, 1'b1, 1'b0);
      run_frame("t2b", GS_BOMB, 1'b1, 1'b0);

      // Five boss hits
      eb_q = '{mk(OFFS, OFFS)};
      pb_q = '{mk(310, 60), mk(310, 60), mk(310, 60), mk(310, 60), mk(310, 60)};
      run_frame("t3", GS_PLAY, 1'b1, 1'b0);

      // Window boundaries: 3 inside, 4 outside; 24 inside, 25 outside
      eb_q = '{mk(104, 100), mk(100, 96), mk(103, 97)};
      pb_q = '{mk(325, 50), mk(300, 26), mk(276, 74), mk(300, 75)};
      run_frame("bound", GS_PLAY, 1'b1, 1'b0);

      // Restart mid-scan after a hitting beat
      start_frame();
      jif.game_state = GS_PLAY;
      jif.eb_valid = 1'b1; jif.eb_x = 10'(101); jif.eb_y = 10'(100); jif.eb_last = 1'b0;
      @(negedge clk);
      jif.eb_valid = 1'b0;
      jif.frame_start = 1'b1;
      @(negedge clk);
      jif.frame_start = 1'b0;
      check_eq("ovr_pulse", 32'(jif.overrun), 1);
      check_eq("ovr_col", 32'(jif.collision), 0);
      eb_q = '{mk(OFFS, OFFS)};
      pb_q = '{mk(OFFS, OFFS)};
      run_frame("ovr", GS_PLAY, 1'b1, 1'b1);
      check_eq("ovr_clear", 32'(jif.overrun), 0);

      // Randomized frames
      for (int f = 0; f < 25; f++) begin
         logic [3:0] gs;
         int r;
         place(int'($urandom_range(16, 1000)), int'($urandom_range(16, 1000)),
               int'($urandom_range(40, 980)), int'($urandom_range(40, 980)));
         r = int'($urandom_range(0, 9));
         gs = (r < 6) ? GS_PLAY : (r == 6) ? GS_COLLISION : (r == 7) ? GS_BOMB :
              (r == 8) ? GS_START : GS_GAMEOVER;
         eb_q.delete();
         pb_q.delete();
         for (int i = 0; i < int'($urandom_range(1, 6)); i++)
            eb_q.push_back(($urandom_range(0, 5) == 0) ? mk(OFFS, OFFS) : near(px, py, P_R + 2));
         for (int i = 0; i < int'($urandom_range(1, 6)); i++)
            pb_q.push_back(($urandom_range(0, 5) == 0) ? mk(OFFS, OFFS) : near(bx, by, B_R + 2));
         run_frame("rnd", gs, ($urandom_range(0, 4) != 0), 1'b0);
      end

      // Asynchronous reset mid-scan with a stream still valid
      place(100, 100, 300, 50);
      start_frame();
      jif.eb_valid = 1'b1; jif.eb_x = 10'(101); jif.eb_y = 10'(100); jif.eb_last = 1'b0;
      check_eq("pre_rst_ready", 32'(jif.eb_ready), 1);
      @(negedge clk);
      #2 hard_reset_n = 1'b0;
      #1;
      check_eq("arst_eb_ready", 32'(jif.eb_ready), 0);
      check_eq("arst_pb_ready", 32'(jif.pb_ready), 0);
      check_eq("arst_hp", 32'(jif.boss_hp), HP0);
      check_eq("arst_die", 32'(jif.die), 0);
      check_eq("arst_ovr", 32'(jif.overrun), 0);
      m_hp  = HP0;
      m_die = 1'b0;
      repeat (2) @(negedge clk);
      hard_reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("post_rst_idle", 32'(jif.eb_ready), 0);
      jif.eb_valid = 1'b0;

      // Drive boss HP to zero: no wrap, die sticks, collision masked
      place(200, 200, 500, 500);
      for (int f = 0; f < 4; f++) begin
         eb_q = '{mk(OFFS, OFFS)};
         pb_q.delete();
         for (int i = 0; i < 60; i++) pb_q.push_back(near(bx, by, B_R));
         run_frame("kill", GS_PLAY, 1'b1, 1'b0);
      end
      eb_q = '{mk(201, 199)};
      pb_q = '{mk(500, 500)};
      run_frame("dead", GS_PLAY, 1'b1, 1'b0);

      // game_reset restores HP and clears die
      @(negedge clk);
      jif.game_reset = 1'b1;
      @(negedge clk);
      jif.game_reset = 1'b0;
      m_hp  = HP0;
      m_die = 1'b0;
      check_eq("grst_hp", 32'(jif.boss_hp), HP0);
      check_eq("grst_die", 32'(jif.die), 0);
      eb_q = '{mk(199, 202)};
      pb_q = '{mk(490, 510)};
      run_frame("after_grst", GS_PLAY, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Produces the `collision` and `die` inputs consumed by the game-control FSM, which is the other end of that interface.
- Each frame it scans the enemy-bullet stream against the player hitbox and the player-bullet stream against the boss hitbox.
- It tracks boss HP, emits at most one `collision` pulse per frame, and holds `die` once the boss HP reaches zero.
- Sits between the bullet engines and the FSM; also exports boss HP to the HUD.

Parameters:
- COORD_W, 10, coordinate width of all x/y buses (unsigned pixels).
- PLAYER_R, 3, player half-hitbox in pixels; hit when |dx|<=PLAYER_R and |dy|<=PLAYER_R.
- BOSS_R, 24, boss half-hitbox in pixels, same rule.
- HP_W, 8, boss HP width.
- BOSS_HP_INIT, 200, boss HP loaded on reset and on game_reset.

Ports:
- clk  in  1  system clock
- hard_reset_n  in  1  asynchronous active-low reset
- game_reset  in  1  synchronous clear pulse from the FSM
- game_en  in  1  game running, driven by the FSM
- game_state  in  4  FSM state code
- frame_start  in  1  one-cycle pulse per video frame
- player_x, player_y  in  COORD_W  player centre
- boss_x, boss_y  in  COORD_W  boss centre
- eb_valid, eb_x, eb_y, eb_last  in  1/COORD_W/COORD_W/1  enemy-bullet stream; eb_last marks the final beat
- eb_ready  out  1  enemy-bullet stream ready
- pb_valid, pb_x, pb_y, pb_last  in  1/COORD_W/COORD_W/1  player-bullet stream
- pb_ready  out  1  player-bullet stream ready
- collision  out  1  one-cycle pulse, to the FSM
- die  out  1  level: boss defeated, to the FSM
- boss_hp  out  HP_W  current boss HP
- overrun  out  1  one-cycle pulse: frame_start arrived before the scan finished

Behaviour:
- Reset (hard_reset_n low, asynchronous):
  - state=IDLE; boss_hp=BOSS_HP_INIT.
  - collision, die, overrun, eb_ready and pb_ready are all 0.
  - Internal flags are cleared.
- game_reset=1 (synchronous, overrides everything else that cycle):
  - boss_hp=BOSS_HP_INIT, die=0, state=IDLE, flags cleared.
- States IDLE, SCAN, REPORT:
  - IDLE: on frame_start with game_en=1, go to SCAN and clear hit_flag, eb_done, pb_done and hit_cnt. Ignore frame_start when game_en=0.
  - SCAN:
    - eb_ready = ~eb_done; pb_ready = ~pb_done. A beat is accepted when valid&ready; both streams may be accepted in the same cycle.
    - An accepted eb beat inside the player window sets hit_flag.
    - An accepted pb beat inside the boss window increments hit_cnt, saturating at 2^HP_W-1.
    - A beat carrying last sets that stream's done flag.
    - When both done flags are set (including the cycle they become set), go to REPORT the next cycle.
    - An empty stream is sent as a single beat with last=1 whose coordinates are ignored only if valid is 0 — no: the producer always sends at least one beat; a sentinel beat off-screen (x=2^COORD_W-1) never hits unless the window contains it.
  - REPORT (one cycle):
    - collision=1 iff hit_flag=1 && game_state==PLAY && game_en=1. It is suppressed in the COLLISION and BOMB states (invulnerable).
    - boss_hp <= (boss_hp > hit_cnt) ? boss_hp-hit_cnt : 0. The HP update is applied only when game_state is PLAY, COLLISION or BOMB.
    - Go to IDLE.
- die=1 from the cycle after boss_hp becomes 0 and sticky until game_reset or reset. collision is never asserted while die=1.
- frame_start while in SCAN or REPORT:
  - overrun pulses for 1 cycle.
  - The partial frame's results are discarded: no collision, no HP change.
  - Flags are cleared and the block re-enters SCAN.
- Distance: |a-b| computed as an unsigned COORD_W subtraction of max minus min; the compare is inclusive.
- Latency: collision is asserted exactly 1 cycle after the cycle in which the second last beat is accepted.
- game_en falling mid-scan: the scan completes, but collision stays masked by the REPORT condition.

Decomposition:
- Shared include stg_defs.vh holds the game_state codes: INITIAL=4'b0000, START=4'b0001, PLAY=4'b0010, COLLISION=4'b1010, BOMB=4'b0110, SUCCESS=4'b1000, GAMEOVER=4'b1001. The FSM and this block both use it.
- One sub-module, hit_window: combinational abs-diff window compare with parameters COORD_W and R. It is instantiated twice, once for the player window and once for the boss window.

Test Plan:
1. Player (100,100), game_state=PLAY; frame with eb beats (110,100) then (102,98,last), pb single beat off-screen with last -> exactly one collision pulse, 1 cycle after the final accepted beat; boss_hp stays 200.
2. Same bullets with game_state=COLLISION, then with game_state=BOMB -> no collision pulse in either case.
3. Boss (300,50); 5 pb beats at (310,60) over a frame in PLAY -> boss_hp 200->195 in REPORT; no collision.
4. BOSS_HP_INIT=3, 5 boss hits in one frame -> boss_hp=0 (no wrap); die=1 from the next cycle; die stays 1 across later frames until game_reset, after which boss_hp=3 and die=0.
5. frame_start pulsed mid-SCAN after a hitting eb beat -> overrun pulses; no collision; the new scan proceeds normally.
6. hard_reset_n low mid-SCAN with eb_valid held high -> outputs drop immediately to reset values (eb_ready=0, boss_hp=200); after release, IDLE waits for frame_start.
